axi_grid_vh_fork: RTL and testbench

//  Splits one AXI grid channel stream onto a vertical and a horizontal output using dimension-ordered XY routing.
//  - did_i.x != MY_X: beat continues on the horizontal output.
//  - did_i.x == MY_X: beat turns onto the vertical output.

---
 rtl/axi_default_param_pkg.sv | 27 ++
 rtl/axi_grid_skid_buf.sv | 79 +++++++
 rtl/axi_grid_vh_fork.sv | 91 +++++++++
 tb/tb_axi_grid_vh_fork.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_default_param_pkg.sv
// Shared grid types for the AXI grid fabric: node IDs and the fork skid buffer sizing.
package axi_default_param_pkg;

    // Default grid dimensions: up to 16 columns by 16 rows.
    localparam int unsigned GridXWidth = 4;
    localparam int unsigned GridYWidth = 4;

    typedef logic [GridXWidth-1:0] grid_x_t;
    typedef logic [GridYWidth-1:0] grid_y_t;

    // Node ID carried with every beat as destination and source.
    typedef struct packed {
        grid_x_t x;
        grid_y_t y;
    } grid_id_t;

    // The fork buffer holds a head entry plus one skid entry.
    localparam int unsigned SkidDepth = 2;

    typedef logic [1:0] skid_cnt_t;

    // Occupancy below which the buffer can take another beat next cycle.
    function automatic logic skid_has_room(input skid_cnt_t count);
        return count < skid_cnt_t'(SkidDepth);
    endfunction

endpackage

// File: rtl/axi_grid_skid_buf.sv
// Two-entry skid buffer with a registered input ready.
// The head entry drives the output; the skid entry absorbs the beat that arrives
// while the head is stalled, so ready_o never depends on ready_i combinationally.
module axi_grid_skid_buf
    import axi_default_param_pkg::*;
#(
    parameter type data_t = logic [7:0]
) (
    input  logic  clk_i,
    input  logic  arst_i,
    input  data_t data_i,
    input  logic  valid_i,
    output logic  ready_o,
    output data_t data_o,
    output logic  valid_o,
    input  logic  ready_i
);

    data_t     head_q, head_d;
    data_t     skid_q, skid_d;
    skid_cnt_t count_q, count_d;
    logic      ready_q;
    logic      push, pop;

    assign ready_o = ready_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;

    assign push = valid_i & ready_q;
    assign pop  = valid_o & ready_i;

    // Next-state for the two entries and the occupancy count.
    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = data_i;
                end else begin
                    skid_d = data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = skid_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count stays put; the entries shift toward the head.
                if (count_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = data_i;
                end else begin
                    head_d = data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; ready is registered from the next occupancy.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
            ready_q <= skid_has_room(count_d);
        end
    end

endmodule

// File: rtl/axi_grid_vh_fork.sv
// Grid node ingress fork: steers each beat to the vertical output when it has
// reached its destination column, otherwise keeps it on the horizontal output.
// Beats are buffered in order behind a two-entry skid buffer; only the head is
// visible, so a stalled head blocks the beats behind it.
module axi_grid_vh_fork
    import axi_default_param_pkg::*;
#(
    parameter type         grid_id_t = axi_default_param_pkg::grid_id_t,
    parameter type         chan_t    = axi_default_param_pkg::grid_id_t,
    parameter int unsigned MY_X      = 0
) (
    input  logic     clk_i,
    input  logic     arst_i,
    input  grid_id_t did_i,
    input  grid_id_t sid_i,
    input  chan_t    chan_i,
    input  logic     valid_i,
    output logic     ready_o,
    output grid_id_t v_did_o,
    output grid_id_t v_sid_o,
    output chan_t    v_chan_o,
    output logic     v_valid_o,
    input  logic     v_ready_i,
    output grid_id_t h_did_o,
    output grid_id_t h_sid_o,
    output chan_t    h_chan_o,
    output logic     h_valid_o,
    input  logic     h_ready_i
);

    // Route decision travels with the beat so the output side never re-compares.
    typedef struct packed {
        grid_id_t did;
        grid_id_t sid;
        chan_t    chan;
        logic     sel_v;
    } beat_t;

    beat_t       in_beat;
    beat_t       head;
    logic        head_valid;
    logic        head_ready;
    logic [31:0] did_x_ext;

    // XY compare at the buffer input; did_i.y is left for the downstream node.
    always_comb begin
        did_x_ext     = 32'(did_i.x);
        in_beat.did   = did_i;
        in_beat.sid   = sid_i;
        in_beat.chan  = chan_i;
        in_beat.sel_v = (did_x_ext == MY_X);
    end

    axi_grid_skid_buf #(
        .data_t (beat_t)
    ) u_skid_buf (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .data_i  (in_beat),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (head),
        .valid_o (head_valid),
        .ready_i (head_ready)
    );

    // Output demux: both sides show the head fields, only the selected valid rises.
    always_comb begin
        v_did_o    = head.did;
        v_sid_o    = head.sid;
        v_chan_o   = head.chan;
        h_did_o    = head.did;
        h_sid_o    = head.sid;
        h_chan_o   = head.chan;
        v_valid_o  = head_valid & head.sel_v;
        h_valid_o  = head_valid & ~head.sel_v;
        head_ready = head.sel_v ? v_ready_i : h_ready_i;
    end

    // The two outputs are mutually exclusive by construction.
    assert property (@(posedge clk_i) disable iff (arst_i) !(v_valid_o && h_valid_o));

    // A stalled vertical beat holds its valid and payload until taken.
    assert property (@(posedge clk_i) disable iff (arst_i)
        (v_valid_o && !v_ready_i) |=> (v_valid_o && $stable(v_chan_o)));

    // A stalled horizontal beat holds its valid and payload until taken.
    assert property (@(posedge clk_i) disable iff (arst_i)
        (h_valid_o && !h_ready_i) |=> (h_valid_o && $stable(h_chan_o)));

endmodule

// File: tb/tb_axi_grid_vh_fork.sv
// Directed bench for the XY vertical/horizontal fork with MY_X = 2.
module tb_axi_grid_vh_fork;
    import axi_default_param_pkg::*;

    logic     clk;
    logic     arst;
    grid_id_t did, sid;
    grid_id_t chan;
    logic     valid;
    logic     ready;
    grid_id_t v_did, v_sid, v_chan;
    logic     v_valid, v_ready;
    grid_id_t h_did, h_sid, h_chan;
    logic     h_valid, h_ready;

    int checks = 0;
    int errors = 0;

    axi_grid_vh_fork #(
        .MY_X (2)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst),
        .did_i     (did),
        .sid_i     (sid),
        .chan_i    (chan),
        .valid_i   (valid),
        .ready_o   (ready),
        .v_did_o   (v_did),
        .v_sid_o   (v_sid),
        .v_chan_o  (v_chan),
        .v_valid_o (v_valid),
        .v_ready_i (v_ready),
        .h_did_o   (h_did),
        .h_sid_o   (h_sid),
        .h_chan_o  (h_chan),
        .h_valid_o (h_valid),
        .h_ready_i (h_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic [7:0] c);
        did   = '{x: x, y: y};
        sid   = '{x: 4'd0, y: 4'd0};
        chan  = c;
        valid = 1'b1;
    endtask

    task automatic test_reset();
        arst    = 1'b1;
        v_ready = 1'b1;
        h_ready = 1'b1;
        drive(4'd2, 4'd3, 8'hC3);
        step();
        step();
        checks++;
        if ({v_valid, h_valid, ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags got v/h/rdy=%b want 001", {v_valid, h_valid, ready});
        end
        checks++;
        if ({v_did, v_sid, v_chan, h_did, h_sid, h_chan} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {v_did, v_sid, v_chan, h_did, h_sid, h_chan});
        end
        arst = 1'b0;
        step();
        valid = 1'b0;
        checks++;
        if ({v_valid, v_chan} !== {1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL reset_first_push got v_valid=%b chan=%h want 1 c3", v_valid, v_chan);
        end
        step();
    endtask

    task automatic test_v_route();
        drive(4'd2, 4'd3, 8'hA5);
        step();
        valid = 1'b0;
        checks++;
        if ({v_valid, h_valid, v_chan, v_did} !== {2'b10, 8'hA5, 8'h23}) begin
            errors++;
            $display("FAIL v_route got v=%b h=%b chan=%h did=%h want 1 0 a5 23",
                     v_valid, h_valid, v_chan, v_did);
        end
        step();
        checks++;
        if ({v_valid, h_valid} !== 2'b00) begin
            errors++;
            $display("FAIL v_route_drain got %b want 00", {v_valid, h_valid});
        end
    endtask

    task automatic test_h_route();
        drive(4'd0, 4'd3, 8'h5A);
        step();
        valid = 1'b0;
        checks++;
        if ({h_valid, v_valid, h_did.x, h_chan} !== {2'b10, 4'd0, 8'h5A}) begin
            errors++;
            $display("FAIL h_route got h=%b v=%b x=%0d chan=%h want 1 0 0 5a",
                     h_valid, v_valid, h_did.x, h_chan);
        end
        step();
    endtask

    task automatic test_backpressure();
        v_ready = 1'b0;
        drive(4'd2, 4'd0, 8'h01);
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_one_entry got ready=%b want 1", ready);
        end
        drive(4'd2, 4'd0, 8'h02);
        step();
        drive(4'd2, 4'd0, 8'h03);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got ready=%b want 0", ready);
        end
        step();
        checks++;
        if ({ready, v_valid, v_chan} !== {2'b01, 8'h01}) begin
            errors++;
            $display("FAIL bp_hold got ready=%b v=%b chan=%h want 0 1 01", ready, v_valid, v_chan);
        end
        valid   = 1'b0;
        v_ready = 1'b1;
        step();
        checks++;
        if ({ready, v_valid, v_chan} !== {2'b11, 8'h02}) begin
            errors++;
            $display("FAIL bp_pop1 got ready=%b v=%b chan=%h want 1 1 02", ready, v_valid, v_chan);
        end
        step();
        checks++;
        if ({v_valid, h_valid} !== 2'b00) begin
            errors++;
            $display("FAIL bp_empty got %b want 00 (beat 3 must not be taken)", {v_valid, h_valid});
        end
    endtask

    task automatic test_head_of_line();
        v_ready = 1'b0;
        h_ready = 1'b1;
        drive(4'd2, 4'd1, 8'h11);
        step();
        drive(4'd5, 4'd1, 8'h22);
        step();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({v_valid, h_valid, v_chan} !== {2'b10, 8'h11}) begin
                errors++;
                $display("FAIL hol_blocked[%0d] got v=%b h=%b chan=%h want 1 0 11",
                         i, v_valid, h_valid, v_chan);
            end
            step();
        end
        v_ready = 1'b1;
        step();
        checks++;
        if ({v_valid, h_valid, h_chan, h_did.x} !== {2'b01, 8'h22, 4'd5}) begin
            errors++;
            $display("FAIL hol_release got v=%b h=%b chan=%h x=%0d want 0 1 22 5",
                     v_valid, h_valid, h_chan, h_did.x);
        end
        step();
    endtask

    task automatic test_stream();
        logic [3:0] xs [100];
        int         bad = 0;
        v_ready = 1'b1;
        h_ready = 1'b1;
        for (int i = 0; i < 100; i++) xs[i] = 4'($urandom_range(0, 7));
        for (int i = 0; i < 100; i++) begin
            drive(xs[i], 4'd7, 8'(i));
            step();
            checks++;
            if ({v_valid, h_valid, v_chan, ready} !== {(xs[i] == 4'd2), (xs[i] != 4'd2), 8'(i), 1'b1}) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL stream[%0d] got v=%b h=%b chan=%h rdy=%b want x=%0d chan=%h",
                             i, v_valid, h_valid, v_chan, ready, xs[i], 8'(i));
            end
        end
        valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stream();
        drive(4'd2, 4'd0, 8'h77);
        step();
        drive(4'd4, 4'd0, 8'h78);
        v_ready = 1'b0;
        step();
        valid = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({v_valid, h_valid, ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset got v/h/rdy=%b want 001", {v_valid, h_valid, ready});
        end
        step();
        arst    = 1'b0;
        v_ready = 1'b1;
        step();
        checks++;
        if ({v_valid, h_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_stale got %b want 00", {v_valid, h_valid});
        end
        drive(4'd6, 4'd0, 8'h99);
        step();
        valid = 1'b0;
        checks++;
        if ({v_valid, h_valid, h_chan} !== {2'b01, 8'h99}) begin
            errors++;
            $display("FAIL mid_reset_fresh got v=%b h=%b chan=%h want 0 1 99", v_valid, h_valid, h_chan);
        end
        step();
    endtask

    initial begin
        valid = 1'b0;
        did   = '0;
        sid   = '0;
        chan  = '0;
        test_reset();
        test_v_route();
        test_h_route();
        test_backpressure();
        test_head_of_line();
        test_stream();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
